// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive sample engine.
package uart_rx_pkg;

    // Receive frame phase. IDLE waits for a falling edge on the line,
    // START qualifies the start bit, DATA shifts in the word, STOP checks
    // the stop bit and hands the word out.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Tick count (0-based) of the mid-bit sample point for an even
    // oversample ratio, e.g. 7 for 16x and 3 for 8x.
    function automatic int mid_point(input int os);
        return os / 2 - 1;
    endfunction

endpackage

// File: rtl/rx_vote3.sv
// Three-sample majority voter for the mid-bit decision.
// The two earlier samples (cnt = MID-1 and MID) are held in a small capture
// register. The third sample is the live line value on the deciding tick
// (cnt = MID+1), so the vote is ready in the same cycle as that tick.
module rx_vote3 (
    input  logic clk,
    input  logic rst,
    input  logic cap_i,
    input  logic rxd_i,
    output logic vote_o
);

    logic [1:0] samp_q;

    // Shift in the line value on each of the two early sample ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_q <= '0;
        end else if (cap_i) begin
            samp_q <= {samp_q[0], rxd_i};
        end
    end

    // Majority of the two captured samples and the live third one.
    always_comb begin
        vote_o = (samp_q[1] & samp_q[0]) |
                 (samp_q[1] & rxd_i)     |
                 (samp_q[0] & rxd_i);
    end

endmodule

// File: rtl/uart_rx_sample_engine.sv
// UART receive timing engine running on the baud generator's oversample
// tick. It finds the start edge, places the mid-bit sample point for any
// even oversample ratio (optionally 3-sample voted), tracks the bit index
// through start/data/stop, shifts in the word LSB first and reports false
// starts and framing errors. All outputs come straight from flops.
module uart_rx_sample_engine
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int VOTE       = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         os_tick,
    input  logic                         rxd,
    output logic                         sample_valid,
    output logic                         sample_bit,
    output logic [$clog2(DATA_BITS)-1:0] bit_index,
    output logic                         bit_done,
    output logic                         frame_done,
    output logic                         frame_err,
    output logic                         false_start,
    output logic [DATA_BITS-1:0]         data_out,
    output logic                         busy
);

    localparam int CW         = $clog2(OVERSAMPLE);
    localparam int BW         = $clog2(DATA_BITS);
    localparam int MID        = mid_point(OVERSAMPLE);
    // With voting the decision waits for the third sample one tick later.
    localparam int DECIDE_CNT = (VOTE != 0) ? MID + 1 : MID;

    localparam logic [CW-1:0] CNT_LAST   = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_DECIDE = CW'(DECIDE_CNT);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);

    // Parameter sanity, caught at elaboration.
    if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4) begin : g_bad_oversample
        $error("uart_rx_sample_engine: OVERSAMPLE must be even and >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_sample_engine: DATA_BITS must be in 5..9");
    end

    rx_state_t            state_q;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [BW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [DATA_BITS-1:0] data_q;
    logic                 sample_valid_q;
    logic                 sample_bit_q;
    logic                 bit_done_q;
    logic                 frame_done_q;
    logic                 frame_err_q;
    logic                 false_start_q;
    logic                 busy_q;

    logic                 decision;
    logic                 at_decide;
    logic                 at_last;

    // Counter wrap, sample-point and end-of-bit decode, and the next value
    // of the data shifter (new bit enters at the MSB so the first bit on
    // the line ends up in bit 0).
    always_comb begin
        cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        at_decide = (cnt_q == CNT_DECIDE);
        at_last   = (cnt_q == CNT_LAST);
        shift_d   = {decision, shift_q[DATA_BITS-1:1]};
    end

    if (VOTE != 0) begin : g_vote
        logic cap;

        // Early samples are only meaningful inside a frame.
        assign cap = os_tick && enable && (state_q != IDLE) &&
                     ((cnt_q == CW'(MID - 1)) || (cnt_q == CW'(MID)));

        rx_vote3 u_vote (
            .clk    (clk),
            .rst    (rst),
            .cap_i  (cap),
            .rxd_i  (rxd),
            .vote_o (decision)
        );
    end else begin : g_single
        assign decision = rxd;
    end

    // Frame state machine with all registered outputs. Pulses default low
    // every cycle and are raised only on the clk after a qualifying tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            bit_idx_q      <= '0;
            shift_q        <= '0;
            data_q         <= '0;
            sample_valid_q <= 1'b0;
            sample_bit_q   <= 1'b0;
            bit_done_q     <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_err_q    <= 1'b0;
            false_start_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            bit_done_q     <= 1'b0;
            frame_done_q   <= 1'b0;
            false_start_q  <= 1'b0;

            if (!enable) begin
                // Disabled: abandon any frame silently, keep data_out.
                state_q <= IDLE;
                cnt_q   <= '0;
                busy_q  <= 1'b0;
            end else if (os_tick) begin
                case (state_q)
                    IDLE: begin
                        if (!rxd) begin
                            state_q <= START;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end

                    START: begin
                        cnt_q <= cnt_d;
                        if (at_decide && decision) begin
                            // Line went back high before mid-bit: noise.
                            false_start_q <= 1'b1;
                            state_q       <= IDLE;
                            cnt_q         <= '0;
                            busy_q        <= 1'b0;
                        end else if (at_last) begin
                            bit_done_q <= 1'b1;
                            state_q    <= DATA;
                            bit_idx_q  <= '0;
                        end
                    end

                    DATA: begin
                        cnt_q <= cnt_d;
                        if (at_decide) begin
                            sample_valid_q <= 1'b1;
                            sample_bit_q   <= decision;
                            shift_q        <= shift_d;
                        end
                        if (at_last) begin
                            bit_done_q <= 1'b1;
                            if (bit_idx_q == BIT_LAST) begin
                                state_q <= STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + BW'(1);
                            end
                        end
                    end

                    STOP: begin
                        cnt_q <= cnt_d;
                        if (at_decide) begin
                            // Leave half a bit early so a back-to-back
                            // start edge is seen on the very next tick.
                            frame_done_q <= 1'b1;
                            frame_err_q  <= ~decision;
                            data_q       <= shift_q;
                            state_q      <= IDLE;
                            cnt_q        <= '0;
                            busy_q       <= 1'b0;
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sample_valid = sample_valid_q;
    assign sample_bit   = sample_bit_q;
    assign bit_index    = bit_idx_q;
    assign bit_done     = bit_done_q;
    assign frame_done   = frame_done_q;
    assign frame_err    = frame_err_q;
    assign false_start  = false_start_q;
    assign data_out     = data_q;
    assign busy         = busy_q;

endmodule
